// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared sprite entry record and commit FSM encoding
//
// Purpose : types shared by sprite_bank and sprite_entry_ram.
//           spr_entry_t is sized for the widest supported coordinate. Narrower
//           instances keep the unused upper bits at zero, and synthesis trims
//           those bits as constant flops.
// Ports   : none (package)
package gfx_pkg;

    localparam int SPR_X_MAX_W = 16;
    localparam int SPR_Y_MAX_W = 16;

    typedef struct packed {
        logic [SPR_X_MAX_W-1:0] x;
        logic [SPR_Y_MAX_W-1:0] y;
        logic                   vis;
        logic                   attr;
        logic                   pos;
    } spr_entry_t;

    localparam int SPR_ENTRY_W = $bits(spr_entry_t);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } spr_state_t;

endpackage

// File: rtl/sprite_entry_ram.sv
// rtl/sprite_entry_ram.sv - flop-based sprite entry array, one write port, one read port
//
// Purpose : holds DEPTH sprite entries. The array resets to zero asynchronously,
//           so a reset during a commit leaves no partially copied frame behind.
// Ports   : clk, reset (async, active-low)
//           we/waddr/wdata : synchronous write of one entry
//           clr_vis        : zero every vis bit. A same-cycle write lands on top.
//           raddr/rdata    : combinational read
module sprite_entry_ram
    import gfx_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [SPR_ENTRY_W-1:0] wdata,
    input  logic                   clr_vis,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [SPR_ENTRY_W-1:0] rdata
);

    spr_entry_t mem_q [DEPTH];
    spr_entry_t mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (clr_vis) begin
                mem_d[i].vis = 1'b0;
            end
            if (we && (waddr == ADDR_W'(i))) begin
                mem_d[i] = spr_entry_t'(wdata);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sprite_bank.sv
// rtl/sprite_bank.sv - double-buffered sprite attribute bank with vsync commit
//
// Purpose : the CPU writes the shadow array at any time outside a commit.
//           A rising edge on vsync copies shadow into the active array, one
//           entry per cycle. Video reads the active array through a registered
//           read port.
// Ports   : clk, reset (async, active-low)
//           wr_valid/wr_ready/wr_sel/wr_x/wr_y/wr_vis/wr_attr/wr_pos : shadow write
//           vsync, rd_sel -> rd_x/rd_y/rd_vis/rd_attr/rd_pos         : video side
//           commit_busy, commit_done (pulse), overrun (sticky)       : status
//           clr_all : clear all shadow vis bits (only with SPRITE_BANK_CLR_EN)
// Options : define SPRITE_BANK_CLR_EN to add the clr_all port and the clear logic.
module sprite_bank
    import gfx_pkg::*;
#(
    parameter  int NUM_SPR = 64,
    parameter  int X_W     = 10,
    parameter  int Y_W     = 9,
    localparam int SEL_W   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic             wr_vis,
    input  logic             wr_attr,
    input  logic             wr_pos,
    input  logic             vsync,
    input  logic [SEL_W-1:0] rd_sel,
`ifdef SPRITE_BANK_CLR_EN
    input  logic             clr_all,
`endif
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic             rd_vis,
    output logic             rd_attr,
    output logic             rd_pos,
    output logic             commit_busy,
    output logic             commit_done,
    output logic             overrun
);

    spr_state_t       state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             vsync_q, vsync_d;
    logic             commit_done_q, commit_done_d;
    logic             overrun_q, overrun_d;
    logic [X_W-1:0]   rd_x_q, rd_x_d;
    logic [Y_W-1:0]   rd_y_q, rd_y_d;
    logic             rd_vis_q, rd_vis_d;
    logic             rd_attr_q, rd_attr_d;
    logic             rd_pos_q, rd_pos_d;

    logic                   vsync_rise;
    logic                   sh_we;
    logic                   act_we;
    logic                   clr_fire;
    spr_entry_t             wr_entry;
    logic [SPR_ENTRY_W-1:0] sh_rd;
    logic [SPR_ENTRY_W-1:0] act_rd;
    spr_entry_t             act_rd_entry;
    logic                   unused_rd_hi;

    assign vsync_rise = vsync && !vsync_q;

`ifdef SPRITE_BANK_CLR_EN
    assign clr_fire = clr_all && (state_q == ST_IDLE);
`else
    assign clr_fire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            vsync_q       <= 1'b0;
            commit_done_q <= 1'b0;
            overrun_q     <= 1'b0;
            rd_x_q        <= '0;
            rd_y_q        <= '0;
            rd_vis_q      <= 1'b0;
            rd_attr_q     <= 1'b0;
            rd_pos_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            vsync_q       <= vsync_d;
            commit_done_q <= commit_done_d;
            overrun_q     <= overrun_d;
            rd_x_q        <= rd_x_d;
            rd_y_q        <= rd_y_d;
            rd_vis_q      <= rd_vis_d;
            rd_attr_q     <= rd_attr_d;
            rd_pos_q      <= rd_pos_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        vsync_d       = vsync;
        commit_done_d = 1'b0;
        overrun_d     = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (vsync_rise) begin
                    state_d = ST_COMMIT;
                    idx_d   = '0;
                end
            end
            ST_COMMIT: begin
                // A new frame boundary during a commit cannot be honoured.
                // It is flagged and then dropped.
                if (vsync_rise) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == SEL_W'(NUM_SPR - 1)) begin
                    state_d       = ST_IDLE;
                    idx_d         = '0;
                    commit_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The active array is read before this cycle's copy lands, so an entry
        // being copied right now still returns its old value.
        rd_x_d    = act_rd_entry.x[X_W-1:0];
        rd_y_d    = act_rd_entry.y[Y_W-1:0];
        rd_vis_d  = act_rd_entry.vis;
        rd_attr_d = act_rd_entry.attr;
        rd_pos_d  = act_rd_entry.pos;
    end

    // Output logic
    always_comb begin
        wr_ready    = (state_q == ST_IDLE);
        commit_busy = (state_q == ST_COMMIT);
        sh_we       = wr_valid && (state_q == ST_IDLE);
        act_we      = (state_q == ST_COMMIT);

        wr_entry            = '0;
        wr_entry.x[X_W-1:0] = wr_x;
        wr_entry.y[Y_W-1:0] = wr_y;
        wr_entry.vis        = wr_vis;
        wr_entry.attr       = wr_attr;
        wr_entry.pos        = wr_pos;
    end

    sprite_entry_ram #(
        .DEPTH  (NUM_SPR),
        .ADDR_W (SEL_W)
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .we      (sh_we),
        .waddr   (wr_sel),
        .wdata   (wr_entry),
        .clr_vis (clr_fire),
        .raddr   (idx_q),
        .rdata   (sh_rd)
    );

    sprite_entry_ram #(
        .DEPTH  (NUM_SPR),
        .ADDR_W (SEL_W)
    ) u_active (
        .clk     (clk),
        .reset   (reset),
        .we      (act_we),
        .waddr   (idx_q),
        .wdata   (sh_rd),
        .clr_vis (1'b0),
        .raddr   (rd_sel),
        .rdata   (act_rd)
    );

    assign act_rd_entry = spr_entry_t'(act_rd);

    // The upper coordinate bits are always zero when X_W/Y_W are narrower than
    // the record. They are folded into this sink so the read path stays fully
    // consumed.
    assign unused_rd_hi = ^act_rd_entry;

    assign rd_x        = rd_x_q;
    assign rd_y        = rd_y_q;
    assign rd_vis      = rd_vis_q;
    assign rd_attr     = rd_attr_q;
    assign rd_pos      = rd_pos_q;
    assign commit_done = commit_done_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/sprite_bank.md
SPRITE_BANK -- requirements
Module: sprite_bank

Interface
REQ-001 SHALL have parameter NUM_SPR, default 64, number of sprite entries (power of two, 2..256).
REQ-002 SHALL have parameter X_W, default 10, sprite X coordinate width.
REQ-003 SHALL have parameter Y_W, default 9, sprite Y coordinate width.
REQ-004 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: wr_valid in 1 write request; wr_ready out 1 write accepted when high with wr_valid; wr_sel in log2(NUM_SPR) entry index.
REQ-006 SHALL have ports: wr_x in X_W; wr_y in Y_W; wr_vis in 1; wr_attr in 1; wr_pos in 1 (entry fields).
REQ-007 SHALL have ports: vsync in 1 frame-boundary level from video timing; rd_sel in log2(NUM_SPR) video read index.
REQ-008 SHALL have ports: rd_x out X_W; rd_y out Y_W; rd_vis, rd_attr, rd_pos out 1 each; commit_busy out 1; commit_done out 1 pulse; overrun out 1 sticky.
REQ-009 SHALL have port clr_all in 1 (present only with SPRITE_BANK_CLR_EN).

Function
REQ-010 SHALL hold two arrays of NUM_SPR entries: shadow (CPU-written) and active (video-read).
REQ-011 SHALL write shadow[wr_sel] at the clock edge where wr_valid && wr_ready.
REQ-012 SHALL drive wr_ready = 1 in IDLE, 0 in COMMIT.
REQ-013 SHALL detect a vsync rising edge via one registered copy of vsync (edge = vsync && !vsync_q).
REQ-014 SHALL have FSM states IDLE, COMMIT; IDLE->COMMIT on vsync edge; COMMIT->IDLE after index NUM_SPR-1 copied.
REQ-015 SHALL in COMMIT copy shadow[idx] to active[idx] one entry per cycle, idx counting 0..NUM_SPR-1, commit = NUM_SPR cycles.
REQ-016 SHALL accept a write coinciding with the vsync edge in IDLE; that write SHALL be included in the commit.
REQ-017 SHALL assert commit_busy in COMMIT only; commit_done for one cycle on the cycle after the last copy.
REQ-018 SHALL ignore a vsync edge occurring in COMMIT and set overrun; overrun clears only on reset.
REQ-019 SHALL register read outputs: rd_* = active[rd_sel] one cycle after rd_sel is presented.
REQ-020 SHALL, when rd_sel equals the entry copied in the same cycle, return the pre-copy active value.
REQ-021 SHALL wrap idx from NUM_SPR-1 to 0 at commit end.

Reset
REQ-022 SHALL on reset low force: state IDLE, idx 0, vsync_q 0, all shadow and active fields 0, rd_* 0, commit_busy 0, commit_done 0, overrun 0.
REQ-023 SHALL abort a commit in progress on reset; active retains no partially copied data (all zero).
REQ-024 SHALL present wr_ready = 1 in the first cycle after reset release.

Configuration
REQ-025 SHALL use macro SPRITE_BANK_CLR_EN.
REQ-026 With SPRITE_BANK_CLR_EN: clr_all high in IDLE SHALL zero every shadow vis bit in one cycle; clr_all and an accepted write same cycle: clear first, write applied on top; clr_all in COMMIT ignored.
REQ-027 Without SPRITE_BANK_CLR_EN: clr_all port absent, no clear logic.

Structure
REQ-028 SHALL place the entry record typedef (x, y, vis, attr, pos) and FSM state encoding in shared package gfx_pkg.
REQ-029 SHALL use one sub-module, sprite_entry_ram, instantiated twice (shadow, active), one write and one read port.

Verification
REQ-030 Write sel=5 x=320 y=200 vis=1; read sel=5 before vsync -> rd_* all 0; pulse vsync, wait commit_done, read sel=5 -> x=320 y=200 vis=1.
REQ-031 vsync edge with NUM_SPR=64 -> commit_busy high exactly 64 cycles, wr_ready low same 64 cycles, commit_done one cycle after.
REQ-032 Write sel=63 same edge as vsync rise -> accepted; after commit rd sel=63 shows new value.
REQ-033 Second vsync rise 10 cycles into commit -> overrun=1, commit ends at cycle 64, no second commit starts.
REQ-034 Reset low at commit cycle 30 -> all outputs 0, state IDLE, wr_ready=1 after release.
REQ-035 With SPRITE_BANK_CLR_EN: vis=1 on sel 0..3, clr_all + write sel=2 vis=1 same cycle, commit -> vis only on sel 2.
